// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: FSM encodings, alignment mask and EX/MEM control field widths
package mem_access_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  localparam logic [1:0] MISALIGN_MASK = 2'b11;
  localparam int EXMEM_M_W = 3;
  localparam int EXMEM_WB_W = 2;
endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences EX/MEM loads/stores onto a req/ack bus, stalls the pipeline, resolves branches
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              branch_i,
  input  logic              zero_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              pc_src_o,
  output logic              flush_o,
  output logic              err_o
);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic req_q, req_d, we_q, we_d, valid_q, valid_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [EXMEM_M_W-1:0] m_ctrl;
  logic access, misaligned, expired;
  assign m_ctrl = {branch_i, mem_read_i, mem_write_i};
  assign access = m_ctrl[1] | m_ctrl[0];
  assign misaligned = |(addr_i[1:0] & MISALIGN_MASK);
  assign expired = cnt_q == CNT_W'(TIMEOUT - 1);
  assign stall_o = (state_q == IDLE && access) || state_q == REQ;
  assign pc_src_o = m_ctrl[2] && zero_i && !stall_o;
  assign flush_o = pc_src_o;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    req_d = req_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (access) begin
        if (misaligned) begin
          state_d = DONE;
          err_d = 1'b1;
          rdata_d = '0;
          valid_d = !mem_write_i;
        end else begin
          state_d = REQ;
          req_d = 1'b1;
          we_d = mem_write_i;
          addr_d = addr_i;
          wdata_d = wdata_i;
          cnt_d = '0;
        end
      end
      REQ: if (bus_ack_i || expired) begin
        state_d = DONE;
        req_d = 1'b0;
        err_d = !bus_ack_i;
        rdata_d = (bus_ack_i && !we_q) ? bus_rdata_i : '0;
        valid_d = !we_q;
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      req_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  assign bus_req_o = req_q;
  assign bus_we_o = we_q;
  assign bus_addr_o = addr_q;
  assign bus_wdata_o = wdata_q;
  assign rdata_o = rdata_q;
  assign rdata_valid_o = valid_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench; dut uses default TIMEOUT, dut_t uses TIMEOUT=4
module tb_mem_access_ctrl;
  typedef struct {
    logic [31:0] rdata;
    logic        valid;
    logic        err;
    int          stall_n;
    int          req_n;
  } exp_t;
  logic clk = 0, rst = 1;
  logic mem_read = 0, mem_write = 0, branch = 0, zero = 0;
  logic [31:0] addr = 0, wdata = 0, rdata_in = 0;
  logic ack = 0, ack_t = 0;
  logic req, we, stall, valid, pc_src, flush, err;
  logic [31:0] baddr, bwdata, rdata;
  logic req_t, we_t, stall_t, valid_t, pc_src_t, flush_t, err_t;
  logic [31:0] baddr_t, bwdata_t, rdata_t;
  logic use_t = 0;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .mem_read_i(mem_read), .mem_write_i(mem_write),
    .branch_i(branch), .zero_i(zero), .addr_i(addr), .wdata_i(wdata),
    .bus_req_o(req), .bus_we_o(we), .bus_addr_o(baddr), .bus_wdata_o(bwdata),
    .bus_ack_i(ack), .bus_rdata_i(rdata_in), .stall_o(stall), .rdata_o(rdata),
    .rdata_valid_o(valid), .pc_src_o(pc_src), .flush_o(flush), .err_o(err));

  mem_access_ctrl #(.TIMEOUT(4)) dut_t (
    .clk(clk), .rst(rst), .mem_read_i(mem_read), .mem_write_i(mem_write),
    .branch_i(branch), .zero_i(zero), .addr_i(addr), .wdata_i(wdata),
    .bus_req_o(req_t), .bus_we_o(we_t), .bus_addr_o(baddr_t), .bus_wdata_o(bwdata_t),
    .bus_ack_i(ack_t), .bus_rdata_i(rdata_in), .stall_o(stall_t), .rdata_o(rdata_t),
    .rdata_valid_o(valid_t), .pc_src_o(pc_src_t), .flush_o(flush_t), .err_o(err_t));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rdat, input exp_t e);
    exp_t p;
    int stall_n = 0, req_n = 0;
    bit done = 0;
    sb.push_back(e);
    mem_read = rd; mem_write = wr; addr = a; wdata = wd;
    #1;
    for (int c = 0; c < 200 && !done; c++) begin
      if (!(use_t ? stall_t : stall)) done = 1;
      else begin
        stall_n++;
        if (use_t ? req_t : req) begin
          req_n++;
          chk("bus_we", use_t ? we_t : we, wr);
          chk("bus_addr", use_t ? baddr_t : baddr, a);
          chk("bus_wdata", use_t ? bwdata_t : bwdata, wd);
        end
        ack = !use_t && req && req_n == ack_at;
        rdata_in = ack ? rdat : 32'h0BAD_0BAD;
        @(negedge clk); #1;
      end
    end
    if (!done) chk("done_reached", 0, 1);
    p = sb.pop_front();
    chk("rdata", use_t ? rdata_t : rdata, p.rdata);
    chk("rdata_valid", use_t ? valid_t : valid, p.valid);
    chk("err", use_t ? err_t : err, p.err);
    chk("stall_cycles", stall_n, p.stall_n);
    chk("req_cycles", req_n, p.req_n);
    mem_read = 0; mem_write = 0; ack = 0;
    @(negedge clk); #1;
    chk("rdata_hold", use_t ? rdata_t : rdata, p.rdata);
    chk("idle_valid", use_t ? valid_t : valid, 0);
    chk("idle_err", use_t ? err_t : err, 0);
  endtask

  initial begin
    #12 rst = 0;
    @(negedge clk); #1;
    chk("rst_req", req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    access(1, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF, '{32'hDEADBEEF, 1'b1, 1'b0, 2, 1});
    access(0, 1, 32'h20, 32'h12345678, 5, 32'h0, '{32'h0, 1'b0, 1'b0, 6, 5});
    access(1, 0, 32'h13, 32'h0, 1, 32'h0, '{32'h0, 1'b1, 1'b1, 1, 0});
    access(1, 0, 32'h44, 32'h0, 3, 32'hCAFEF00D, '{32'hCAFEF00D, 1'b1, 1'b0, 4, 3});
    access(1, 1, 32'h30, 32'hA5A5A5A5, 2, 32'h0, '{32'h0, 1'b0, 1'b0, 3, 2});
    access(0, 1, 32'h2A, 32'h1, 1, 32'h0, '{32'h0, 1'b0, 1'b1, 1, 0});
    branch = 1; zero = 1; #1;
    chk("br_taken_pc", pc_src, 1);
    chk("br_taken_flush", flush, 1);
    zero = 0; #1;
    chk("br_nt_pc", pc_src, 0);
    chk("br_nt_flush", flush, 0);
    zero = 1; mem_read = 1; addr = 32'h50; #1;
    chk("br_stalled_pc", pc_src, 0);
    chk("br_stalled_flush", flush, 0);
    branch = 0; zero = 0; mem_read = 0;
    @(negedge clk);
    mem_read = 1; addr = 32'h40;
    @(negedge clk); #1;
    chk("mid_req", req, 1);
    chk("mid_stall", stall, 1);
    #1 rst = 1; mem_read = 0;
    #1;
    chk("async_rst_req", req, 0);
    chk("async_rst_stall", stall, 0);
    @(negedge clk) rst = 0;
    @(negedge clk); #1;
    chk("post_rst_stall", stall, 0);
    chk("post_rst_req", req, 0);
    chk("post_rst_err", err, 0);
    use_t = 1;
    access(1, 0, 32'h80, 32'h0, 0, 32'h0, '{32'h0, 1'b1, 1'b1, 5, 4});
    ack_t = 1;
    @(negedge clk); #1;
    ack_t = 0;
    chk("late_ack_req", req_t, 0);
    chk("late_ack_stall", stall_t, 0);
    chk("late_ack_err", err_t, 0);
    chk("late_ack_valid", valid_t, 0);
    @(negedge clk); #1;
    chk("late_ack_req2", req_t, 0);
    chk("late_ack_err2", err_t, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
